// File: rtl/truth_table_capture_pkg.sv
// Shared types and sizing helpers for the truth-table capture engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: run-state enum, default vector geometry, width helper functions.
package tt_pkg;

    // Run states of the capture engine.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tt_state_e;

    // Default geometry: four DUT inputs, twenty clocks per vector.
    localparam int N_IN_DEF        = 4;
    localparam int HOLD_CYCLES_DEF = 20;
    localparam int NUM_VEC         = 2 ** N_IN_DEF;

    // Vector count for a given input count.
    function automatic int vec_count(input int n_in);
        return 2 ** n_in;
    endfunction

    // Width needed to count 0..n-1; never narrower than one bit so that a
    // hold of a single clock still yields a legal register.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a mismatch counter able to hold 0..2**n_in without wrapping.
    function automatic int mcnt_width(input int n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/truth_table_capture_if.sv
// Bundle between the capture engine and whoever drives/observes it.
// Latency: n/a (wiring only).
// Backpressure: none; start is a level request sampled every clock.
//
// Ports: start/expected/f flow into the engine (slave), the vector and the
// result fields flow back out. master = harness side, slave = engine side.
interface truth_table_capture_if #(
    parameter int N_IN = 4
);
    localparam int NV = 2 ** N_IN;

    logic            start;
    logic [NV-1:0]   expected;
    logic            f;
    logic [N_IN-1:0] vec;
    logic            busy;
    logic            done;
    logic            pass;
    logic [NV-1:0]   table_out;
    logic [N_IN:0]   mismatch_cnt;
    logic [N_IN-1:0] first_fail;

    modport master (
        output start, expected, f,
        input  vec, busy, done, pass, table_out, mismatch_cnt, first_fail
    );

    modport slave (
        input  start, expected, f,
        output vec, busy, done, pass, table_out, mismatch_cnt, first_fail
    );

endinterface

// File: rtl/truth_table_capture_hold_counter.sv
// Counts the clocks a vector has been held and flags the last one.
// Latency: tc_o is combinational from the count register.
// Backpressure: none; advances whenever en_i is high, clr_i has priority.
//
// Ports: clk, rst_n (sync, active low); clr_i restarts the count at 0;
// en_i advances it; tc_o is high while the count sits on HOLD_CYCLES-1.
module tt_hold_counter
    import tt_pkg::*;
#(
    parameter int HOLD_CYCLES = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int             CW   = cnt_width(HOLD_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // With HOLD_CYCLES==1 LAST is 0 and the count never leaves 0, so every
    // enabled clock is a terminal clock.
    assign tc_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_capture.sv
// Walks every input vector, samples f at the end of each hold, compares
// against a golden table. Latency: 2**N_IN*HOLD_CYCLES clocks accept->done.
// Backpressure: none; start is ignored while a run is in progress.
//
// Ports: clk, rst_n (sync, active low); bus (slave) carries start, expected
// and f in, and vec, busy, done, pass, table_out, mismatch_cnt, first_fail out.
module truth_table_capture
    import tt_pkg::*;
#(
    parameter int N_IN        = N_IN_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    truth_table_capture_if.slave bus
);
    localparam int NV = vec_count(N_IN);
    localparam int MW = mcnt_width(N_IN);

    tt_state_e       state_q;
    logic [N_IN-1:0] vec_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [NV-1:0]   table_q;
    logic [NV-1:0]   exp_q;
    logic [MW-1:0]   mcnt_q;
    logic [MW-1:0]   mcnt_d;
    logic [N_IN-1:0] first_fail_q;

    logic accept;
    logic running;
    logic tc;
    logic miss;
    logic last_vec;

    // A new run may begin from IDLE or DONE only.
    assign accept   = bus.start && (state_q != RUN);
    assign running  = (state_q == RUN);
    assign miss     = (bus.f != exp_q[vec_q]);
    assign last_vec = &vec_q;

    // Count including the sample taken on this edge; pass is derived from it
    // so that a failure on the final vector is not missed.
    assign mcnt_d = mcnt_q + MW'(miss);

    tt_hold_counter #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (accept),
        .en_i  (running),
        .tc_o  (tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            table_q      <= '0;
            exp_q        <= '0;
            mcnt_q       <= '0;
            first_fail_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        exp_q        <= bus.expected;
                        vec_q        <= '0;
                        table_q      <= '0;
                        mcnt_q       <= '0;
                        first_fail_q <= '0;
                        pass_q       <= 1'b0;
                        done_q       <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    if (tc) begin
                        table_q[vec_q] <= bus.f;
                        if (miss) begin
                            mcnt_q <= mcnt_d;
                            // Only the first mismatch of the run sets the index.
                            if (mcnt_q == '0) begin
                                first_fail_q <= vec_q;
                            end
                        end
                        if (last_vec) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (mcnt_d == '0);
                        end else begin
                            vec_q <= vec_q + N_IN'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.vec          = vec_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.table_out    = table_q;
    assign bus.mismatch_cnt = mcnt_q;
    assign bus.first_fail   = first_fail_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: three engines (hold 1, 2, 20) share stimulus.
// Each is compared every cycle to a model derived from elapsed clocks.
// Literal expectations pin latency and key result words.
module tb_truth_table_capture;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] expected;
    int          mode;
    logic [15:0] rtab;

    logic [3:0]  vec_a  [3];
    logic        busy_a [3];
    logic        done_a [3];
    logic        pass_a [3];
    logic [15:0] tab_a  [3];
    logic [4:0]  mc_a   [3];
    logic [3:0]  ff_a   [3];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit chk_en = 0;

    // Function under test seen by the engines, selected by mode.
    function automatic logic f_of(input int m, input logic [3:0] v, input logic [15:0] rt);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ^v;
            3:       return (^v) ^ (v == 4'd11);
            default: return rt[v];
        endcase
    endfunction

    function automatic int hold_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 20);
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g
        truth_table_capture_if #(.N_IN(4)) bus ();
        assign bus.start    = start;
        assign bus.expected = expected;
        assign bus.f        = f_of(mode, bus.vec, rtab);
        truth_table_capture #(
            .N_IN        (4),
            .HOLD_CYCLES ((k == 0) ? 1 : ((k == 1) ? 2 : 20))
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
        assign vec_a[k]  = bus.vec;
        assign busy_a[k] = bus.busy;
        assign done_a[k] = bus.done;
        assign pass_a[k] = bus.pass;
        assign tab_a[k]  = bus.table_out;
        assign mc_a[k]   = bus.mismatch_cnt;
        assign ff_a[k]   = bus.first_fail;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model state: a run is described only by its accept time, latched golden
    // table and the f table that was in force.
    bit          m_act [3];
    int          m_e   [3];
    logic [15:0] m_exp [3];
    logic [15:0] m_ft  [3];
    int          t_acc [3];
    int          lat   [3];
    bit          dprev [3];

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_act[k] = 0;
                m_e[k]   = 0;
            end else if (start && (!m_act[k] || m_e[k] >= 16 * hold_of(k))) begin
                m_act[k] = 1;
                m_e[k]   = 0;
                m_exp[k] = expected;
                for (int i = 0; i < 16; i++) m_ft[k][i] = f_of(mode, 4'(i), rtab);
                t_acc[k] = cyc;
            end else if (m_act[k] && m_e[k] < 16 * hold_of(k)) begin
                m_e[k]++;
            end
        end
    end

    // Expected {vec, busy, done, pass, table, mismatch_cnt, first_fail}.
    function automatic logic [31:0] model_out(input int k);
        int          h    = hold_of(k);
        int          ns   = 0;
        int          nm   = 0;
        int          ffi  = 0;
        int          v    = 0;
        logic [15:0] tab  = '0;
        bit          busy = 0;
        bit          done = 0;
        if (m_act[k]) begin
            ns   = (m_e[k] / h > 16) ? 16 : m_e[k] / h;
            v    = (m_e[k] / h > 15) ? 15 : m_e[k] / h;
            busy = (m_e[k] < 16 * h);
            done = !busy;
            for (int i = 0; i < ns; i++) begin
                tab[i] = m_ft[k][i];
                if (m_ft[k][i] != m_exp[k][i]) begin
                    if (nm == 0) ffi = i;
                    nm++;
                end
            end
        end
        return {4'(v), busy, done, done && (nm == 0), tab, 5'(nm), 4'(ffi)};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("dut%0d cyc%0d", k, cyc),
                    {vec_a[k], busy_a[k], done_a[k], pass_a[k], tab_a[k], mc_a[k], ff_a[k]},
                    model_out(k));
                if (done_a[k] && !dprev[k]) lat[k] = cyc - t_acc[k];
                dprev[k] = done_a[k];
            end
        end
    end

    task automatic wait_done(input string nm);
        int n = 0;
        while (!(done_a[0] && done_a[1] && done_a[2]) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk({nm, " done timeout"}, done_a[2], 1);
        @(negedge clk);
    endtask

    task automatic run(input int m, input logic [15:0] e, input string nm);
        @(negedge clk);
        mode     = m;
        expected = e;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(nm);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        expected = '0;
        mode     = 0;
        rtab     = '0;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        rst_n = 1'b1;

        // f=0 against all-zero golden table.
        run(0, 16'h0000, "zero");
        chk("lat_h1", lat[0], 16);
        chk("lat_h2", lat[1], 32);
        chk("lat_h20", lat[2], 320);
        chk("zero_pass", pass_a[1], 1);
        chk("zero_tab", tab_a[1], 16'h0000);
        chk("zero_mc", mc_a[1], 0);

        // Parity function matches its golden table.
        run(2, 16'h6996, "xor");
        chk("xor_tab", tab_a[2], 16'h6996);
        chk("xor_pass", pass_a[2], 1);
        chk("xor_lat", lat[2], 320);

        // f stuck at 1 against zeros: every vector fails.
        run(1, 16'h0000, "ones");
        chk("ones_tab", tab_a[2], 16'hFFFF);
        chk("ones_mc", mc_a[2], 5'b10000);
        chk("ones_ff", ff_a[2], 0);
        chk("ones_pass", pass_a[0], 0);

        // Single fault at vector 11.
        run(3, 16'h6996, "v11");
        chk("v11_mc", mc_a[2], 1);
        chk("v11_ff", ff_a[2], 11);
        chk("v11_tab", tab_a[2], 16'h6196);
        chk("v11_pass", pass_a[1], 0);

        // Mid-run: ignored start, then reset coinciding with start.
        @(negedge clk);
        mode = 2; expected = 16'h6996; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 200 && vec_a[2] != 4'd3; n++) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 200 && vec_a[2] != 4'd5; n++) @(negedge clk);
        chk("rst_at_vec5", vec_a[2], 5);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        chk("rst_busy", busy_a[2], 0);
        chk("rst_vec", vec_a[2], 0);
        repeat (30) @(negedge clk);
        chk("rst_nodone", done_a[2], 0);

        // Restart from DONE with a new golden table.
        run(2, 16'h6996, "pre");
        @(negedge clk);
        mode = 1; expected = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("re_done_clr", done_a[2], 0);
        chk("re_tab_clr", tab_a[2], 16'h0000);
        wait_done("re");
        chk("re_pass", pass_a[2], 1);
        chk("re_tab", tab_a[2], 16'hFFFF);

        // Random functions, golden tables sometimes equal, sometimes sparse-flipped.
        for (int r = 0; r < 6; r++) begin
            rtab = 16'($urandom);
            run(4, (r % 2 == 0) ? rtab : rtab ^ 16'($urandom & $urandom & $urandom), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
